la_trace_seq: RTL and testbench

Sequencer for the logic-analyzer trace RAM in the SIMD-DLX debug path. It consumes the per-cycle sample strobe `la_we` from the LA run/step controller and generates trace-RAM write enables and addresses as a circular buffer. It handles arm, trigger capture and post-trigger counting, then freezes the buffer. A host read port translates a logical sample index (0 = oldest) into a physical RAM address.

---
 rtl/la_trace_seq.sv | 131 +++++++++++++
 tb/tb_la_trace_seq.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/la_trace_seq.sv
// Logic-analyzer trace RAM sequencer: circular write pointer, arm/trigger/post-trigger
// capture with freeze, and a logical-to-physical read port. Optional LA_TRIG_EDGE_EN selects edge trigger.
module la_trace_seq #(
    parameter int AW = 5
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          arm,
    input  logic          la_we,
    input  logic          trig,
    input  logic [AW-1:0] post_cnt,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [AW-1:0] trig_addr,
    output logic          wrapped,
    output logic          done,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_idx,
    output logic [AW-1:0] rd_addr,
    output logic          rd_valid
);

    typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;

    state_t        state_q,     state_d;
    logic [AW-1:0] wr_addr_q,   wr_addr_d;
    logic [AW-1:0] trig_addr_q, trig_addr_d;
    logic          wrapped_q,   wrapped_d;
    logic [AW-1:0] remain_q,    remain_d;
    logic [AW-1:0] rd_addr_q,   rd_addr_d;
    logic          rd_valid_q,  rd_valid_d;
    logic          hit;
    logic [AW-1:0] oldest;

`ifdef LA_TRIG_EDGE_EN
    // Previous sampled trigger level; preset high so a level already asserted at arm is not an edge.
    logic trig_q;
    assign hit = trig & ~trig_q;

    always_ff @(posedge CLK) begin
        if (RESET || arm) begin
            trig_q <= 1'b1;
        end else if (la_we) begin
            trig_q <= trig;
        end
    end
`else
    assign hit = trig;
`endif

    assign wr_en  = la_we & ((state_q == ARMED) | (state_q == POST)) & ~arm;
    assign oldest = wrapped_q ? wr_addr_q : '0;

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        wr_addr_d   = wr_addr_q;
        trig_addr_d = trig_addr_q;
        wrapped_d   = wrapped_q;
        remain_d    = remain_q;
        rd_addr_d   = rd_addr_q;
        rd_valid_d  = 1'b0;

        if (arm) begin
            state_d   = ARMED;
            wr_addr_d = '0;
            wrapped_d = 1'b0;
            remain_d  = '0;
        end else begin
            if (wr_en) begin
                wr_addr_d = wr_addr_q + 1'b1;
                if (wr_addr_q == '1) wrapped_d = 1'b1;
            end
            unique case (state_q)
                ARMED: begin
                    if (wr_en && hit) begin
                        trig_addr_d = wr_addr_q;
                        if (post_cnt == '0) begin
                            state_d = DONE;
                        end else begin
                            remain_d = post_cnt;
                            state_d  = POST;
                        end
                    end
                end
                POST: begin
                    if (wr_en) begin
                        remain_d = remain_q - 1'b1;
                        if (remain_q == AW'(1)) state_d = DONE;
                    end
                end
                default: ;
            endcase
        end

        // Reads translate logical index (0 = oldest) only once the buffer is frozen.
        if (rd_req && state_q == DONE) begin
            rd_addr_d  = oldest + rd_idx;
            rd_valid_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            wr_addr_q   <= '0;
            trig_addr_q <= '0;
            wrapped_q   <= 1'b0;
            remain_q    <= '0;
            rd_addr_q   <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_addr_q   <= wr_addr_d;
            trig_addr_q <= trig_addr_d;
            wrapped_q   <= wrapped_d;
            remain_q    <= remain_d;
            rd_addr_q   <= rd_addr_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    assign wr_addr   = wr_addr_q;
    assign trig_addr = trig_addr_q;
    assign wrapped   = wrapped_q;
    assign done      = (state_q == DONE);
    assign rd_addr   = rd_addr_q;
    assign rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_la_trace_seq.sv
// Scoreboard bench for la_trace_seq: stimulus pushes expected write/read addresses,
// a negedge monitor pops them whenever wr_en or rd_valid is presented.
module tb_la_trace_seq;

    localparam int AW = 5;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          arm, la_we, trig, rd_req;
    logic [AW-1:0] post_cnt, rd_idx;
    logic          wr_en, wrapped, done, rd_valid;
    logic [AW-1:0] wr_addr, trig_addr, rd_addr;

    logic [AW-1:0] wq[$];
    logic [AW-1:0] rq[$];
    int            pass_cnt = 0;
    int            total_cnt = 0;

    la_trace_seq #(.AW(AW)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .arm       (arm),
        .la_we     (la_we),
        .trig      (trig),
        .post_cnt  (post_cnt),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .trig_addr (trig_addr),
        .wrapped   (wrapped),
        .done      (done),
        .rd_req    (rd_req),
        .rd_idx    (rd_idx),
        .rd_addr   (rd_addr),
        .rd_valid  (rd_valid)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic a, input logic we, input logic tr, input logic [AW-1:0] pc);
        arm      = a;
        la_we    = we;
        trig     = tr;
        post_cnt = pc;
    endtask

    // Monitor: every presented write or read result must match the oldest expected entry.
    initial begin
        forever begin
            @(negedge CLK);
            if (wr_en) begin
                if (wq.size() == 0) check("unexpected_wr_en", 32'(wr_addr), 32'hFFFF_FFFF);
                else check("wr_addr", 32'(wr_addr), 32'(wq.pop_front()));
            end
            if (rd_valid) begin
                if (rq.size() == 0) check("unexpected_rd_valid", 32'(rd_addr), 32'hFFFF_FFFF);
                else check("rd_addr", 32'(rd_addr), 32'(rq.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        RESET = 1'b1; rd_req = 1'b0; rd_idx = '0;
        drive(1'b0, 1'b0, 1'b0, '0);
        tick(); tick();
        RESET = 1'b0;
        check("rst_done", 32'(done), 0);
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_trig_addr", 32'(trig_addr), 0);
        check("rst_wrapped", 32'(wrapped), 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_wr_en", 32'(wr_en), 0);

        // Basic capture: trigger on 4th sample, post_cnt 3 -> writes at 0..6.
        drive(1'b1, 1'b0, 1'b0, '0); tick();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, (i == 3), AW'(3));
            if (i < 7) wq.push_back(AW'(i));
            tick();
            if (i == 5) check("basic_done_early", 32'(done), 0);
            if (i == 6) check("basic_done_rise", 32'(done), 1);
        end
        drive(1'b0, 1'b0, 1'b0, '0);
        check("basic_trig_addr", 32'(trig_addr), 3);
        check("basic_wr_addr", 32'(wr_addr), 7);
        check("basic_wrapped", 32'(wrapped), 0);
        tick();

        // Wrap: 40 plain samples, trigger on 41st with post_cnt 0 -> address 8.
        drive(1'b1, 1'b0, 1'b0, '0); tick();
        for (int i = 0; i <= 40; i++) begin
            drive(1'b0, 1'b1, (i == 40), '0);
            wq.push_back(AW'(i));
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, '0);
        check("wrap_done", 32'(done), 1);
        check("wrap_trig_addr", 32'(trig_addr), 8);
        check("wrap_wrapped", 32'(wrapped), 1);
        check("wrap_wr_addr", 32'(wr_addr), 9);
        rd_req = 1'b1; rd_idx = AW'(0);  rq.push_back(AW'(9)); tick();
        check("rd0_valid", 32'(rd_valid), 1);
        check("rd0_addr", 32'(rd_addr), 9);
        rd_idx = AW'(31); rq.push_back(AW'(8)); tick();
        rd_req = 1'b0;
        check("rd31_valid", 32'(rd_valid), 1);
        check("rd31_addr", 32'(rd_addr), 8);
        tick();
        check("rd_valid_drop", 32'(rd_valid), 0);

        // Re-arm collision in POST with remain = 2.
        drive(1'b1, 1'b0, 1'b0, '0); tick();
        drive(1'b0, 1'b1, 1'b0, AW'(5)); wq.push_back(AW'(0)); tick();
        drive(1'b0, 1'b1, 1'b1, AW'(5)); wq.push_back(AW'(1)); tick();
        for (int i = 2; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b0, AW'(5)); wq.push_back(AW'(i)); tick();
        end
        check("pre_collide_wr_addr", 32'(wr_addr), 5);
        drive(1'b1, 1'b1, 1'b0, '0); #1;
        check("collide_wr_en", 32'(wr_en), 0);
        tick();
        check("collide_wr_addr", 32'(wr_addr), 0);
        check("collide_wrapped", 32'(wrapped), 0);
        check("collide_done", 32'(done), 0);
        drive(1'b0, 1'b1, 1'b0, '0); wq.push_back(AW'(0)); tick();
        check("rearm_wr_addr", 32'(wr_addr), 1);

        // Read request while ARMED is ignored.
        drive(1'b0, 1'b0, 1'b0, '0);
        rd_req = 1'b1; rd_idx = AW'(3); tick();
        rd_req = 1'b0;
        check("rd_armed_valid", 32'(rd_valid), 0);
        check("rd_armed_addr", 32'(rd_addr), 8);

        // Reset during POST.
        drive(1'b0, 1'b1, 1'b1, AW'(10)); wq.push_back(AW'(1)); tick();
        check("post_trig_addr", 32'(trig_addr), 1);
        drive(1'b0, 1'b0, 1'b0, '0);
        RESET = 1'b1; tick(); RESET = 1'b0;
        check("rst2_trig_addr", 32'(trig_addr), 0);
        check("rst2_wr_addr", 32'(wr_addr), 0);
        check("rst2_rd_addr", 32'(rd_addr), 0);
        check("rst2_done", 32'(done), 0);
        drive(1'b0, 1'b1, 1'b0, '0); #1;
        check("rst2_wr_en", 32'(wr_en), 0);
        tick(); tick(); tick();

        // Trigger mode: trig held high from before arm.
        drive(1'b0, 1'b0, 1'b1, '0); tick();
        drive(1'b1, 1'b0, 1'b1, '0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b1, AW'(2)); wq.push_back(AW'(i)); tick();
        end
`ifdef LA_TRIG_EDGE_EN
        check("edge_no_trig", 32'(done), 0);
        drive(1'b0, 1'b1, 1'b0, '0); wq.push_back(AW'(3)); tick();
        drive(1'b0, 1'b1, 1'b1, '0); wq.push_back(AW'(4)); tick();
        check("edge_trig_addr", 32'(trig_addr), 4);
        check("edge_done", 32'(done), 1);
`else
        check("level_trig_addr", 32'(trig_addr), 0);
        check("level_done", 32'(done), 1);
`endif
        drive(1'b0, 1'b0, 1'b0, '0);
        tick(); tick();
        check("wq_drained", wq.size(), 0);
        check("rq_drained", rq.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
